// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_AW = 5;
    localparam int unsigned FETCH_IW = 16;
    localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the imem handshake, decode hand-off and control signals of the
// fetch sequencer. master = fetch unit, slave = its environment.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int unsigned AW = FETCH_AW,
    parameter int unsigned IW = FETCH_IW
) ();

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;

    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          stall;

    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          halt;
    logic          resume;
    logic [AW-1:0] pc;
    logic          halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted,
        input  imem_ack, imem_rdata, stall, br_taken, br_target, halt, resume
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted,
        output imem_ack, imem_rdata, stall, br_taken, br_target, halt, resume
    );

endinterface

// File: rtl/fetch_buf.sv
// Instruction holding register presented to decode: load captures a new
// word and its address, clear drops the valid flag.
module fetch_buf #(
    parameter int unsigned AW = 5,
    parameter int unsigned IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [IW-1:0] i_instr,
    input  logic [AW-1:0] i_pc,
    output logic          o_valid,
    output logic [IW-1:0] o_instr,
    output logic [AW-1:0] o_pc
);

    logic          r_valid;
    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_pc;

    // Capture on load (load wins over clear); clear only drops valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues instruction-memory reads over req/ack
// and hands instructions to decode, applying redirects, stall and halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned   AW       = FETCH_AW,
    parameter int unsigned   IW       = FETCH_IW,
    parameter logic [AW-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    fetch_state_e  r_state;
    fetch_state_e  w_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic          r_squash;
    logic          w_squash_next;
    logic [AW-1:0] r_sq_addr;
    logic [AW-1:0] w_sq_addr_next;
    logic          r_halted;

    logic          w_req;
    logic          w_load;
    logic          w_clr;
    logic [AW-1:0] w_pc_inc;

    logic          w_valid;
    logic [IW-1:0] w_instr;
    logic [AW-1:0] w_instr_pc;

    assign w_pc_inc = r_pc + AW'(1);
    assign w_req    = (r_state == ST_REQ) || ((r_state == ST_VALID) && !bus.stall);

    // A redirected request stays on its original address until its ack
    // retires it; only then does the fetch move to the new pc.
    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_squash ? r_sq_addr : r_pc;

    // The holding register is only valid while the FSM sits in VALID
    assign w_clr = (w_next != ST_VALID);

    // Next-state, next-pc and squash decisions (halt > branch > stall > increment)
    always_comb begin
        w_next         = r_state;
        w_pc_next      = r_pc;
        w_squash_next  = r_squash;
        w_sq_addr_next = r_sq_addr;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.halt) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_REQ;
                    if (bus.br_taken) begin
                        w_pc_next = bus.br_target;
                    end
                end
            end

            ST_REQ: begin
                if (bus.halt) begin
                    // finish the outstanding read, throw it away, then stop
                    if (bus.imem_ack) begin
                        w_next        = ST_HALT;
                        w_squash_next = 1'b0;
                    end
                end else if (bus.br_taken) begin
                    w_pc_next = bus.br_target;
                    if (bus.imem_ack) begin
                        w_squash_next = 1'b0;
                    end else if (!r_squash) begin
                        w_squash_next  = 1'b1;
                        w_sq_addr_next = r_pc;
                    end
                end else if (bus.imem_ack) begin
                    if (r_squash) begin
                        w_squash_next = 1'b0;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = w_pc_inc;
                        w_next    = ST_VALID;
                    end
                end
            end

            ST_VALID: begin
                if (bus.halt) begin
                    w_next = ST_HALT;
                end else if (bus.br_taken) begin
                    w_pc_next = bus.br_target;
                    w_next    = ST_REQ;
                    if (w_req && !bus.imem_ack) begin
                        w_squash_next  = 1'b1;
                        w_sq_addr_next = r_pc;
                    end
                end else if (bus.stall) begin
                    w_next = ST_VALID;
                end else if (bus.imem_ack) begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc_inc;
                end else begin
                    w_next = ST_REQ;
                end
            end

            ST_HALT: begin
                if (bus.br_taken) begin
                    w_pc_next = bus.br_target;
                end
                if (bus.resume && !bus.halt) begin
                    w_next = ST_REQ;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, pc, squash tracking and registered halted flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_squash  <= 1'b0;
            r_sq_addr <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pc      <= w_pc_next;
            r_squash  <= w_squash_next;
            r_sq_addr <= w_sq_addr_next;
            r_halted  <= (w_next == ST_HALT);
        end
    end

    fetch_buf #(
        .AW (AW),
        .IW (IW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clr),
        .i_instr (bus.imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_valid),
        .o_instr (w_instr),
        .o_pc    (w_instr_pc)
    );

    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_instr;
    assign bus.instr_pc    = w_instr_pc;
    assign bus.pc          = r_pc;
    assign bus.halted      = r_halted;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch controller for the 16-bit single-core processor. Owns the program counter and sequences instruction-memory reads through a req/ack handshake. Presents each fetched instruction to decode with valid/stall flow control, and applies branch redirects, stall back-pressure and halt/resume. Sits between instruction memory and the decode stage; the execute stage supplies redirects.

## Interface
- AW, 5: PC / instruction-address width (32-word instruction space)
- IW, 16: instruction width
- RESET_PC, 0: fetch address after reset
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  AW  fetch address; equals pc; stable while imem_req=1 and no ack
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  IW  instruction word, valid with imem_ack
- instr_valid  out  1  instr/instr_pc hold an unconsumed instruction
- instr  out  IW  registered instruction word
- instr_pc  out  AW  address of instr
- stall  in  1  decode cannot accept; instruction consumed when instr_valid=1 and stall=0
- br_taken  in  1  redirect request, single-cycle pulse
- br_target  in  AW  redirect address
- halt  in  1  level; stop fetching
- resume  in  1  pulse; leave HALT
- pc  out  AW  next fetch address
- halted  out  1  high in HALT

## Operation
- States: IDLE, REQ, VALID, HALT.
- IDLE: entered on reset; goes to REQ on the first clock edge after reset release.
- REQ: imem_req=1.
  - On imem_ack without squash: capture instr=imem_rdata and instr_pc=pc; pc<=pc+1; go to VALID.
- VALID: instr_valid=1; imem_req=!stall.
  - stall=1: hold instr and pc.
  - stall=0 with ack: load the next instruction and stay in VALID (back-to-back).
  - stall=0 without ack: go to REQ.
- Increment is modulo 2^AW: pc 31 goes to 0 with no error.
- Redirect (br_taken=1), any state:
  - pc<=br_target, and instr_valid is cleared next cycle.
  - If a request is outstanding without ack, set the squash flag. imem_addr stays at the old address until ack; that data is discarded and the flag cleared. Then request br_target.
  - br_taken coincident with ack: discard the returned data.
- Halt (halt=1) in REQ: wait for the outstanding ack, discard it, go to HALT. In IDLE or VALID: go to HALT next cycle.
- Any instruction still in VALID when entering HALT is dropped. pc keeps the address of the first unconsumed instruction.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - br_taken updates pc and stays in HALT.
  - resume (with halt=0) goes to REQ.
- Priority: reset > halt > br_taken > stall > increment.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, squash=0.
- Reset asserted mid-handshake drops imem_req at once; no ack is tracked afterwards.
- Throughput with zero-wait memory: 1 instruction/cycle. Latency from imem_ack to instr_valid is 1 cycle.
- Redirect penalty with zero-wait memory: br_taken in cycle t, imem_addr=br_target in cycle t+1, target instruction valid in cycle t+2.
- All outputs are registered except imem_req and imem_addr, which are decoded from state/pc.

## Structure
- Package fetch_pkg: state enum (IDLE/REQ/VALID/HALT) and the default AW, IW and RESET_PC constants.
- One sub-module, fetch_buf: the instr/instr_pc holding register with load and clear. The FSM, pc and squash flag stay in the top.

## Test plan
- Reset release, zero-wait memory returning rdata=0x1000+addr: imem_addr 0,1,2,… on consecutive cycles; instr_valid continuous; instr_pc 0,1,2.
- Wrap: run from pc=30: instr_pc sequence 30, 31, 0.
- Stall: stall=1 for 3 cycles while instr_pc=4: instr and instr_pc=4 held; imem_req=0; pc=5. Release stall: instr_pc=5 appears the next cycle.
- Redirect during a 3-cycle-wait request at addr 7, br_target=20: imem_addr stays 7 until ack; that data is not presented; the next request is addr 20; the next instr_pc=20.
- Halt: halt=1 while in VALID at instr_pc=9: halted=1; imem_req=0; pc=10 (first unconsumed). resume: fetch restarts at addr 10.
- Asynchronous reset mid-request at addr 12: imem_req drops immediately; pc=0. The first request after release is at addr 0.
